// File: rtl/iob_stream_native_bridge_pkg.sv
// Shared definitions for iob_stream_native_bridge: FSM state encoding and the native
// request/response field layout used by the interconnect header.
package iob_stream_native_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } bridge_state_e;

   // Native request is {valid, addr, wdata, wstrb}, response is {ready, rdata}, MSB first.
   localparam int unsigned IOB_VALID_W = 1;
   localparam int unsigned IOB_READY_W = 1;
   localparam int unsigned IOB_WSTRB_POS = 0;
   localparam int unsigned IOB_RDATA_POS = 0;

   function automatic int unsigned iob_wstrb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned iob_wdata_pos(input int unsigned data_w);
      return IOB_WSTRB_POS + iob_wstrb_w(data_w);
   endfunction

   function automatic int unsigned iob_addr_pos(input int unsigned data_w);
      return iob_wdata_pos(data_w) + data_w;
   endfunction

   function automatic int unsigned iob_valid_pos(input int unsigned addr_w,
                                                 input int unsigned data_w);
      return iob_addr_pos(data_w) + addr_w;
   endfunction

   function automatic int unsigned iob_req_w(input int unsigned addr_w,
                                             input int unsigned data_w);
      return iob_valid_pos(addr_w, data_w) + IOB_VALID_W;
   endfunction

   function automatic int unsigned iob_ready_pos(input int unsigned data_w);
      return IOB_RDATA_POS + data_w;
   endfunction

   function automatic int unsigned iob_resp_w(input int unsigned data_w);
      return iob_ready_pos(data_w) + IOB_READY_W;
   endfunction

endpackage

// File: rtl/iob_bridge_rsp_fifo.sv
// First-word-fall-through response FIFO for iob_stream_native_bridge; head word is visible
// on pop_data whenever valid is high, and reads as zero while empty.
module iob_bridge_rsp_fifo #(
   parameter int unsigned W       = 33,
   parameter int unsigned DEPTH_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [W-1:0]       push_data,
   input  logic               pop,
   output logic [W-1:0]       pop_data,
   output logic               valid,
   output logic [DEPTH_W:0]   level
);

   localparam int unsigned DEPTH = 2 ** DEPTH_W;
   localparam logic [DEPTH_W:0] FULL_LVL = (DEPTH_W + 1)'(DEPTH);

   logic [W-1:0]         mem_q [DEPTH];
   logic [DEPTH_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DEPTH_W:0]     level_q;
   logic                 do_push, do_pop;

   assign valid   = (level_q != '0);
   assign do_push = push & (level_q != FULL_LVL);
   assign do_pop  = pop & valid;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
         end
         if (do_push && !do_pop) begin
            level_q <= level_q + (DEPTH_W + 1)'(1);
         end else if (!do_push && do_pop) begin
            level_q <= level_q - (DEPTH_W + 1)'(1);
         end
      end
   end

   assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
   assign level    = level_q;

endmodule

// File: rtl/iob_stream_native_bridge.sv
// CPU stream port to IOb native bus bridge: read bursts become single-word native accesses.
// Define IOB_BRIDGE_EXTMEM_EN to force the address MSB high once boot has finished.
module iob_stream_native_bridge
   import iob_stream_native_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned BURST_W = 3,
   parameter int unsigned FIFO_W  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                boot,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_wr,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   input  logic [BURST_W-1:0]  cmd_len,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_last,
   output logic                rsp_error,
   output logic                req_valid,
   output logic [ADDR_W-1:0]   req_addr,
   output logic [DATA_W-1:0]   req_wdata,
   output logic [DATA_W/8-1:0] req_wstrb,
   input  logic                resp_ready,
   input  logic [DATA_W-1:0]   resp_rdata
);

   localparam int unsigned STRB_W = iob_wstrb_w(DATA_W);
   localparam logic [FIFO_W:0] FIFO_DEPTH = (FIFO_W + 1)'(2 ** FIFO_W);
   localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

   bridge_state_e        state_q, state_d;
   logic                 wr_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [STRB_W-1:0]    wstrb_q;
   logic [BURST_W-1:0]   len_q, beat_q;
   logic [ADDR_W-1:0]    native_addr;
   logic [FIFO_W:0]      fifo_level;
   logic [DATA_W:0]      fifo_dout;
   logic                 cmd_fire, ack, last_beat, done_on_ack, issue_ok, push;

   assign cmd_fire    = cmd_valid & cmd_ready;
   assign ack         = req_valid & resp_ready;
   assign last_beat   = (beat_q == len_q);
   assign done_on_ack = wr_q | last_beat;
   // A read is only issued with a free slot, so its response can always be pushed.
   assign issue_ok    = wr_q | (fifo_level < FIFO_DEPTH);
   assign push        = ack & ~wr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (ack) begin
               state_d = done_on_ack ? StIdle : StIssue;
            end else if (issue_ok) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (ack) begin
               state_d = done_on_ack ? StIdle : StIssue;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      req_valid = 1'b0;
      unique case (state_q)
         StIdle:  cmd_ready = 1'b1;
         StIssue: req_valid = issue_ok;
         StWait:  req_valid = 1'b1;
         default: ;
      endcase
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      if (req_valid) begin
         req_addr  = native_addr;
         req_wdata = wdata_q;
         req_wstrb = wr_q ? wstrb_q : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else if (cmd_fire) begin
         wr_q    <= cmd_wr;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         wstrb_q <= cmd_wstrb;
         len_q   <= cmd_len;
         beat_q  <= '0;
      end else if (push && !last_beat) begin
         beat_q <= beat_q + BURST_W'(1);
         addr_q <= addr_q + ADDR_INC;
      end
   end

`ifdef IOB_BRIDGE_EXTMEM_EN
   logic boot_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         boot_q <= 1'b1;
      end else if (cmd_fire) begin
         boot_q <= boot;
      end
   end

   assign native_addr = {addr_q[ADDR_W-1] | ~boot_q, addr_q[ADDR_W-2:0]};
`else
   logic unused_boot;
   assign unused_boot = boot;
   assign native_addr = addr_q;
`endif

   iob_bridge_rsp_fifo #(
      .W       (DATA_W + 1),
      .DEPTH_W (FIFO_W)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({last_beat, resp_rdata}),
      .pop       (rsp_ready),
      .pop_data  (fifo_dout),
      .valid     (rsp_valid),
      .level     (fifo_level)
   );

   assign rsp_data  = fifo_dout[DATA_W-1:0];
   assign rsp_last  = fifo_dout[DATA_W];
   assign rsp_error = 1'b0;

endmodule

// File: tb/tb_iob_stream_native_bridge.sv
// Self-checking bench for iob_stream_native_bridge (FIFO_W=1): directed table, corner
// sequences and randomized commands against a transaction-level model.
module tb_iob_stream_native_bridge;

   localparam int DEPTH = 2;
`ifdef IOB_BRIDGE_EXTMEM_EN
   localparam bit EXTMEM = 1'b1;
   localparam logic [31:0] EXT_ADDR = 32'h8000_0010;
`else
   localparam bit EXTMEM = 1'b0;
   localparam logic [31:0] EXT_ADDR = 32'h0000_0010;
`endif

   logic        clk, rst, boot;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [2:0]  cmd_len;
   logic        rsp_valid, rsp_ready, rsp_last, rsp_error;
   logic [31:0] rsp_data;
   logic        req_valid;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_ready;
   logic [31:0] resp_rdata;

   int checks = 0;
   int failures = 0;

   iob_stream_native_bridge #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .BURST_W (3),
      .FIFO_W  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .boot       (boot),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_wr     (cmd_wr),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_wstrb  (cmd_wstrb),
      .cmd_len    (cmd_len),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_last   (rsp_last),
      .rsp_error  (rsp_error),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Address the native side should see for a given beat address and sampled boot flag.
   function automatic logic [31:0] map_addr(input logic [31:0] a, input logic b);
      logic ext;
      ext = EXTMEM && !b;
      return {a[31] | ext, a[30:0]};
   endfunction

   task automatic reset_midway();
      resp_ready = 1'b0;
      rsp_ready  = 1'b0;
      cmd_valid  = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_req_addr", req_addr, 0);
      chk("rst_req_wdata", req_wdata, 0);
      chk("rst_req_wstrb", req_wstrb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_last", rsp_last, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_req_valid", req_valid, 0);
   endtask

   // Issues one command and plays both the native memory and the CPU response side,
   // checking every cycle against the expected beat sequence and response queue.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] len, input logic b,
                          input int lat, input logic [31:0] rdata_fix, input int hold,
                          input int abort_beat, output logic [31:0] first_addr,
                          output logic [31:0] last_addr, output int acks_hold);
      logic [32:0] q[$];
      int          n, idx, cnt;
      logic        outst, fresh, done;
      logic [31:0] d;
      n = wr ? 1 : int'(len) + 1;
      idx = 0; cnt = 0; outst = 1'b0; fresh = 1'b0; done = 1'b0;
      acks_hold = 0; first_addr = '0; last_addr = '0;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
      cmd_wstrb = strb; cmd_len = len; boot = b;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         cmd_valid = 1'b0; boot = ~b;
         cmd_addr = $urandom; cmd_wdata = $urandom; cmd_len = 3'($urandom);
         chk("cmd_ready", cmd_ready, idx == n);
         chk("req_valid", req_valid, outst || (idx < n && (wr || q.size() < DEPTH)));
         fresh = 1'b0;
         if (req_valid && idx < n) begin
            chk("req_addr", req_addr, map_addr(addr + 32'(4 * idx), b));
            chk("req_wstrb", req_wstrb, wr ? strb : 4'h0);
            if (wr) chk("req_wdata", req_wdata, wdata);
            if (!outst) begin
               outst = 1'b1; fresh = 1'b1;
               cnt = (lat > 0) ? lat : int'($urandom_range(1, 4));
               if (idx == 0) first_addr = req_addr;
               last_addr = req_addr;
               if (abort_beat == idx) begin
                  reset_midway();
                  done = 1'b1;
                  break;
               end
            end
         end
         chk("rsp_valid", rsp_valid, q.size() > 0);
         chk("rsp_error", rsp_error, 0);
         if (rsp_valid && q.size() > 0) begin
            chk("rsp_data", rsp_data, q[0][31:0]);
            chk("rsp_last", rsp_last, q[0][32]);
         end
         if (idx == n && q.size() == 0) begin
            done = 1'b1;
            break;
         end
         rsp_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (rsp_ready && q.size() > 0) void'(q.pop_front());
         resp_ready = 1'b0;
         resp_rdata = $urandom;
         if (outst && !fresh) begin
            cnt--;
            if (cnt == 0) begin
               d = (rdata_fix != 0) ? rdata_fix : $urandom;
               resp_ready = 1'b1;
               resp_rdata = d;
               if (!wr) q.push_back({idx == n - 1, d});
               idx++;
               outst = 1'b0;
               if (cyc < hold) acks_hold++;
            end
         end
      end
      rsp_ready = 1'b0;
      resp_ready = 1'b0;
      chk("cmd_complete", done, 1);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  len;
      int          lat;
      logic [31:0] rdata;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   vec_t        vecs[6];
   logic [31:0] fa, la, r;
   int          ah;

   initial begin
      rst = 1'b1; boot = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; cmd_len = '0; rsp_ready = 1'b0;
      resp_ready = 1'b0; resp_rdata = '0;

      vecs[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd0, 3, 32'hDEAD_BEEF,
                  32'h0000_0100, 32'h0000_0100};
      vecs[1] = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd3, 0, 32'h0,
                  32'h0000_0200, 32'h0000_020C};
      vecs[2] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'h3, 3'd5, 3, 32'h0,
                  32'h0000_0040, 32'h0000_0040};
      vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 3'd1, 0, 32'h0,
                  32'hFFFF_FFFC, 32'h0000_0000};
      vecs[4] = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'd7, 0, 32'h0,
                  32'h0000_1000, 32'h0000_101C};
      vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'hF, 3'd0, 1, 32'h0,
                  32'hFFFF_FFFC, 32'hFFFF_FFFC};

      repeat (2) @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_req_valid", req_valid, 0);
      chk("reset_req_addr", req_addr, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_last", rsp_last, 0);
      rst = 1'b0;

      // Stray acknowledge while no request is pending must change nothing.
      @(negedge clk);
      resp_ready = 1'b1; resp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("idle_ack_rsp_valid", rsp_valid, 0);
      chk("idle_ack_req_valid", req_valid, 0);
      chk("idle_ack_cmd_ready", cmd_ready, 1);

      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].len, 1'b1,
                 vecs[i].lat, vecs[i].rdata, 0, -1, fa, la, ah);
         chk($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_first);
         chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
      end

      // Back-pressure: only as many acks as FIFO slots until the CPU side pops.
      run_cmd(1'b0, 32'h0000_0300, 32'h0, 4'h0, 3'd7, 1'b1, 0, 32'h0, 40, -1, fa, la, ah);
      chk("bp_acks_while_held", ah, DEPTH);
      chk("bp_last_addr", la, 32'h0000_031C);

      // Reset during beat 2 of a 4-beat burst, then a normal command.
      run_cmd(1'b0, 32'h0000_0500, 32'h0, 4'h0, 3'd3, 1'b1, 0, 32'h0, 100, 1, fa, la, ah);
      run_cmd(1'b0, 32'h0000_0600, 32'h0, 4'h0, 3'd1, 1'b1, 2, 32'h0, 0, -1, fa, la, ah);
      chk("after_rst_last_addr", la, 32'h0000_0604);

      run_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 1'b0, 0, 32'h0, 0, -1, fa, la, ah);
      chk("extmem_boot0_addr", fa, EXT_ADDR);
      run_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 1'b1, 0, 32'h0, 0, -1, fa, la, ah);
      chk("extmem_boot1_addr", fa, 32'h0000_0010);

      for (int i = 0; i < 25; i++) begin
         r = $urandom;
         run_cmd(1'($urandom_range(0, 1)), {r[31:2], 2'b00}, $urandom, 4'($urandom),
                 3'($urandom), 1'($urandom_range(0, 1)), 0, 32'h0,
                 int'($urandom_range(0, 10)), -1, fa, la, ah);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iob_stream_native_bridge.md
Name: iob_stream_native_bridge

Overview:
Parametrised bridge between a CPU-style stream port (cmd valid/ready, rsp valid/ready) and the IOb native request/response bus.
- Read bursts (cache-line refills) are split into sequential single-word native accesses.
- Read data is buffered in a response FIFO so the CPU side may back-pressure.
- One instance sits per CPU bus (instruction or data) between the core and the interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
BURST_W, 3, cmd_len width; max burst = 2^BURST_W words
FIFO_W, 3, log2 response FIFO depth; must satisfy FIFO_W >= 1

Ports:
clk  in  1  clock
rst  in  1  reset (see Behaviour)
boot  in  1  boot-in-progress flag, used only with the optional feature
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address of first word
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte enables
cmd_len  in  BURST_W  read beats minus 1; ignored for writes
rsp_valid  out  1  read data valid
rsp_ready  in  1  read data consumed when valid&ready
rsp_data  out  DATA_W  read data
rsp_last  out  1  final beat of a burst
rsp_error  out  1  tied 0, since the native bus has no error
req_valid  out  1  native request valid
req_addr  out  ADDR_W  native address
req_wdata  out  DATA_W  native write data
req_wstrb  out  DATA_W/8  native strobes; all 0 for reads
resp_ready  in  1  native acknowledge, one-cycle pulse
resp_rdata  in  DATA_W  native read data, valid with resp_ready

Behaviour:
- Reset and clock:
  - Reset rst, asynchronous, active-high; clock clk.
  - On reset all outputs are 0, except cmd_ready=1. State returns to IDLE, the FIFO is emptied and the beat counter is cleared.
  - Reset mid-burst abandons the burst; queued responses are lost.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr/wdata/wstrb/wr/len, set beat counter=0 and go to ISSUE.
- ISSUE:
  - cmd_ready=0.
  - Reads: wait until FIFO level < 2^FIFO_W, then assert req_valid and go to WAIT.
  - Writes: assert req_valid immediately and go to WAIT.
- WAIT:
  - req_valid, req_addr, req_wdata and req_wstrb are held stable until resp_ready.
  - On resp_ready for a read, push {resp_rdata, last}, where last = (beat==len).
  - On resp_ready, if the command is a write or last is set, return to IDLE. Otherwise increment beat and address, then go to ISSUE.
  - resp_ready asserted while req_valid=0 is ignored.
- Latency:
  - cmd accept at cycle N gives req_valid at cycle N+1 (registered).
  - Ack at cycle M gives rsp_valid at M+1 (FWFT FIFO).
  - The next beat's req_valid appears at M+1 if the FIFO is not full.
- Addressing:
  - Increment per beat is DATA_W/8.
  - Wraps modulo 2^ADDR_W; no boundary splitting.
- Writes produce no rsp beat.
- FIFO:
  - Simultaneous push and pop leaves the level unchanged.
  - Pop occurs on rsp_valid&rsp_ready.
  - A full FIFO stalls issue but never drops data, because a request is only issued while a slot is free.
- No native request is ever retracted once req_valid=1.

Optional Feature:
Macro IOB_BRIDGE_EXTMEM_EN.
- Defined:
  - boot is sampled at cmd accept.
  - req_addr[ADDR_W-1] = cmd_addr[ADDR_W-1] | ~boot_sampled, which routes to external memory after boot.
  - Remaining address bits pass unchanged.
- Undefined: address passes unchanged and boot is unused.

Decomposition:
- Shared package: FSM state encodings, plus the native req/resp field widths and offsets already used by the interconnect header (valid, addr, wdata, wstrb, ready, rdata).
- One sub-module: iob_bridge_rsp_fifo. It is a synchronous first-word-fall-through FIFO, width DATA_W+1, depth 2^FIFO_W, with level output.

Test Plan:
- Single read, addr 0x100, cmd_len=0, native ack after 3 cycles with 0xDEADBEEF -> one rsp beat: data=0xDEADBEEF, last=1, at ack+1.
- Read burst, addr 0x200, cmd_len=3, ack latency randomised 1-4 -> req_addr 0x200, 0x204, 0x208, 0x20C in order; 4 rsp beats in order; last only on beat 4.
- Write, addr 0x40, data 0x12345678, wstrb 0x3 -> single native req with identical fields held until ack; no rsp_valid; cmd_ready back at ack+1.
- rsp_ready=0 with FIFO_W=1 and an 8-beat burst -> exactly 2 native acks accepted, then req_valid stays 0 until a pop. All 8 words delivered intact after rsp_ready=1.
- rst asserted during beat 2 of a 4-beat burst -> all outputs at reset values immediately, cmd_ready=1 afterwards, FIFO empty, new command served normally.
- Wrap: read, addr 0xFFFFFFFC, cmd_len=1 -> req_addr 0xFFFFFFFC then 0x00000000.
- With IOB_BRIDGE_EXTMEM_EN: boot=0 and addr 0x00000010 -> req_addr 0x80000010. boot=1 -> 0x00000010.
